mul_pipe_unit: RTL

- Parametrised, fully pipelined integer multiply unit for the EX stage of the dual-issue core.
- Accepts one MULT/MULTU per cycle and returns a 2×WIDTH HI/LO result after LATENCY cycles.
- Carries an opaque tag (ROB address/age) alongside each operation.
- Uses valid/ready handshakes on both sides, so WB backpressure stalls the pipe without dropping work. A flush squashes all in-flight operations.

---
 rtl/mul_pipe_unit_pkg.sv | 23 ++
 rtl/mul_pipe_unit_if.sv | 33 +++
 rtl/mul_pipe_stage.sv | 43 ++++
 rtl/mul_pipe_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pipe_unit_pkg.sv
// mul_pipe_unit_pkg: shared op encodings and pipeline depth bounds for the
// pipelined multiply unit.
package mul_pipe_unit_pkg;

  localparam int MUL_OP_W    = 3;
  localparam int MUL_LAT_MIN = 2;
  localparam int MUL_LAT_MAX = 8;

  typedef enum logic [MUL_OP_W-1:0] {
    MUL_OP_MULT  = 3'b000,
    MUL_OP_MULTU = 3'b001,
    MUL_OP_MADD  = 3'b100,
    MUL_OP_MADDU = 3'b101,
    MUL_OP_MSUB  = 3'b110,
    MUL_OP_MSUBU = 3'b111
  } mul_op_e;

  // Signed ops sign-extend their operands into the (WIDTH+1)-bit multiplier.
  function automatic logic op_is_signed(input logic [MUL_OP_W-1:0] op);
    return (op == MUL_OP_MULT) || (op == MUL_OP_MADD) || (op == MUL_OP_MSUB);
  endfunction

endpackage

// File: rtl/mul_pipe_unit_if.sv
// mul_pipe_unit_if: issue-side and writeback-side valid/ready handshakes of
// the multiply unit. The unit uses the slave modport, its driver the master.
interface mul_pipe_unit_if
  import mul_pipe_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 6
);

  logic                in_valid;
  logic                in_ready;
  logic [MUL_OP_W-1:0] in_op;
  logic [WIDTH-1:0]    in_a;
  logic [WIDTH-1:0]    in_b;
  logic [TAG_W-1:0]    in_tag;

  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_hi;
  logic [WIDTH-1:0]    out_lo;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_hi, out_lo, out_tag
  );

endinterface

// File: rtl/mul_pipe_stage.sv
// mul_pipe_stage: one valid/op/tag/data register stage of the multiply pipe.
// The whole pipe advances on en; flush drops the valid bit only.
module mul_pipe_stage #(
  parameter int OP_W   = 3,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 66
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              d_valid,
  input  logic [OP_W-1:0]   d_op,
  input  logic [TAG_W-1:0]  d_tag,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [OP_W-1:0]   q_op,
  output logic [TAG_W-1:0]  q_tag,
  output logic [DATA_W-1:0] q_data
);

  // Stage register: valid cleared by flush, payload follows the global enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_op    <= '0;
      q_tag   <= '0;
      q_data  <= '0;
    end else begin
      if (flush) begin
        q_valid <= 1'b0;
      end else if (en) begin
        q_valid <= d_valid;
      end
      if (en) begin
        q_op   <= d_op;
        q_tag  <= d_tag;
        q_data <= d_data;
      end
    end
  end

endmodule

// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: fully pipelined MULT/MULTU unit with tag pass-through and
// valid/ready backpressure. Optional HI/LO accumulator with MADD/MSUB ops is
// enabled by defining MUL_PIPE_ACC_EN.
module mul_pipe_unit
  import mul_pipe_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4,
  parameter int TAG_W   = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  mul_pipe_unit_if.slave bus,
  output logic          busy
);

  // S1 holds both operands widened to WIDTH+1; later stages hold the full
  // signed product, which is the same width, so every stage is uniform.
  localparam int DATA_W = 2*WIDTH + 2;

  if (LATENCY < MUL_LAT_MIN || LATENCY > MUL_LAT_MAX) begin : g_bad_latency
    $error("mul_pipe_unit: LATENCY out of range 2..8");
  end

  logic                en;
  logic                so_valid;
  logic [WIDTH-1:0]    so_hi;
  logic [WIDTH-1:0]    so_lo;
  logic [TAG_W-1:0]    so_tag;

  // d_* is the input of stage i (index LATENCY is the output stage SO),
  // q_* is the registered content of S1..S(LATENCY-1).
  logic                d_valid [1:LATENCY];
  logic [MUL_OP_W-1:0] d_op    [1:LATENCY];
  logic [TAG_W-1:0]    d_tag   [1:LATENCY];
  logic [DATA_W-1:0]   d_data  [1:LATENCY];

  logic                q_valid [1:LATENCY-1];
  logic [MUL_OP_W-1:0] q_op    [1:LATENCY-1];
  logic [TAG_W-1:0]    q_tag   [1:LATENCY-1];
  logic [DATA_W-1:0]   q_data  [1:LATENCY-1];

  logic                a_sx;
  logic                b_sx;
  logic signed [DATA_W-1:0] mul_a;
  logic signed [DATA_W-1:0] mul_b;
  logic signed [DATA_W-1:0] prod;

  logic [2*WIDTH-1:0]  prod_lo;
  logic [2*WIDTH-1:0]  so_result;
  logic                prod_unused;

  assign en           = ~so_valid | bus.out_ready;
  assign bus.in_ready = en;

  assign bus.out_valid = so_valid;
  assign bus.out_hi    = so_hi;
  assign bus.out_lo    = so_lo;
  assign bus.out_tag   = so_tag;

  assign a_sx = op_is_signed(bus.in_op) & bus.in_a[WIDTH-1];
  assign b_sx = op_is_signed(bus.in_op) & bus.in_b[WIDTH-1];

  assign d_valid[1] = bus.in_valid & en;
  assign d_op[1]    = bus.in_op;
  assign d_tag[1]   = bus.in_tag;
  assign d_data[1]  = {a_sx, bus.in_a, b_sx, bus.in_b};

  // Full-width signed product of the S1 operands; the stages behind it only
  // carry the result, leaving room for retiming.
  assign mul_a = {{(WIDTH+1){q_data[1][DATA_W-1]}}, q_data[1][DATA_W-1:WIDTH+1]};
  assign mul_b = {{(WIDTH+1){q_data[1][WIDTH]}},    q_data[1][WIDTH:0]};
  assign prod  = mul_a * mul_b;

  for (genvar i = 2; i <= LATENCY; i++) begin : g_link
    assign d_valid[i] = q_valid[i-1];
    assign d_op[i]    = q_op[i-1];
    assign d_tag[i]   = q_tag[i-1];
    if (i == 2) begin : g_prod
      assign d_data[i] = prod;
    end else begin : g_carry
      assign d_data[i] = q_data[i-1];
    end
  end

  for (genvar i = 1; i < LATENCY; i++) begin : g_stage
    mul_pipe_stage #(
      .OP_W   (MUL_OP_W),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .flush   (flush),
      .d_valid (d_valid[i]),
      .d_op    (d_op[i]),
      .d_tag   (d_tag[i]),
      .d_data  (d_data[i]),
      .q_valid (q_valid[i]),
      .q_op    (q_op[i]),
      .q_tag   (q_tag[i]),
      .q_data  (q_data[i])
    );
  end

  // Only the low 2*WIDTH product bits reach HI/LO; the two top bits are the
  // sign growth of the widened operands.
  assign prod_lo     = d_data[LATENCY][2*WIDTH-1:0];
  assign prod_unused = ^d_data[LATENCY][DATA_W-1:2*WIDTH];

`ifdef MUL_PIPE_ACC_EN
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_eff;

  // The result sitting in SO is the youngest HI/LO value, so it is forwarded
  // ahead of ACC to let back-to-back accumulates chain.
  assign acc_eff = so_valid ? {so_hi, so_lo} : acc;

  // Output-stage result select, including accumulate ops.
  always_comb begin
    so_result = '0;
    case (d_op[LATENCY])
      MUL_OP_MULT, MUL_OP_MULTU: so_result = prod_lo;
      MUL_OP_MADD, MUL_OP_MADDU: so_result = acc_eff + prod_lo;
      MUL_OP_MSUB, MUL_OP_MSUBU: so_result = acc_eff - prod_lo;
      default:                   so_result = '0;
    endcase
  end

  // Architectural HI/LO: updated only when WB takes the result; flush leaves it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (so_valid && bus.out_ready) begin
      acc <= {so_hi, so_lo};
    end
  end
`else
  // Output-stage result select; anything but MULT/MULTU retires as zero.
  always_comb begin
    so_result = '0;
    case (d_op[LATENCY])
      MUL_OP_MULT, MUL_OP_MULTU: so_result = prod_lo;
      default:                   so_result = '0;
    endcase
  end
`endif

  // Output stage: holds under backpressure, flush drops the valid result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      so_valid <= 1'b0;
      so_hi    <= '0;
      so_lo    <= '0;
      so_tag   <= '0;
    end else begin
      if (flush) begin
        so_valid <= 1'b0;
      end else if (en) begin
        so_valid <= d_valid[LATENCY];
      end
      if (en && d_valid[LATENCY] && !flush) begin
        so_hi  <= so_result[2*WIDTH-1:WIDTH];
        so_lo  <= so_result[WIDTH-1:0];
        so_tag <= d_tag[LATENCY];
      end
    end
  end

  // Any occupied stage keeps the issue logic informed.
  always_comb begin
    busy = so_valid;
    for (int i = 1; i < LATENCY; i++) begin
      busy = busy | q_valid[i];
    end
  end

endmodule
